// File: rtl/spi_slave_ctrl.sv
// SPI mode-0 slave front end for the 128x16 register memory. It oversamples the SPI pins on clk,
// turns 24-bit frames into memory address/data/rwb controls, and shifts read data back onto MISO.
module spi_slave_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [ADDR_W-1:0] mem_add,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_rwb,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int HDR_W   = 1 + ADDR_W;
  localparam int FRAME_W = HDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HDR       = 3'd1,
    S_RD_WAIT   = 3'd2,
    S_RD_DATA   = 3'd3,
    S_WR_DATA   = 3'd4,
    S_WR_COMMIT = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_d;
  logic                   r_cs_d;

  logic [CNT_W-1:0]  r_bit_cnt;
  logic [DATA_W-2:0] r_rx_sr;
  logic [DATA_W-1:0] r_tx_sr;
  logic              r_wait;
  logic              r_miso;
  logic              r_miso_oe;
  logic [ADDR_W-1:0] r_mem_add;
  logic [DATA_W-1:0] r_mem_data_in;
  logic              r_mem_rwb;
  logic              r_frame_done;
  logic              r_frame_err;

  logic w_sclk;
  logic w_cs_n;
  logic w_mosi;
  logic w_rise;
  logic w_fall;
  logic w_cs_fall;
  logic w_rw;

  logic w_cnt_clr;
  logic w_cnt_inc;
  logic w_rx_shift;
  logic w_hdr_latch;
  logic w_wr_latch;
  logic w_tx_load;
  logic w_tx_shift;
  logic w_abort;

  assign w_sclk    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_n    = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
  assign w_rise    = w_sclk & ~r_sclk_d & ~w_cs_n;
  assign w_fall    = ~w_sclk & r_sclk_d & ~w_cs_n;
  assign w_cs_fall = r_cs_d & ~w_cs_n;
  // After seven header shifts the R/W bit sits at the top of the header window.
  assign w_rw      = r_rx_sr[ADDR_W-1];

  // Pin synchronisers and one-cycle delayed copies for edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_sclk_d    <= w_sclk;
      r_cs_d      <= w_cs_n;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_rx_shift  = 1'b0;
    w_hdr_latch = 1'b0;
    w_wr_latch  = 1'b0;
    w_tx_load   = 1'b0;
    w_tx_shift  = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cs_fall) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = S_HDR;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_HDR: begin
        if (w_cs_n) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_rise) begin
          w_rx_shift = 1'b1;
          w_cnt_inc  = 1'b1;
          if (r_bit_cnt == CNT_W'(HDR_W - 1)) begin
            w_hdr_latch = 1'b1;
            w_state_nxt = w_rw ? S_RD_WAIT : S_WR_DATA;
          end else begin
            w_state_nxt = S_HDR;
          end
        end else begin
          w_state_nxt = S_HDR;
        end
      end
      S_RD_WAIT: begin
        if (w_cs_n) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_wait) begin
          w_tx_load   = 1'b1;
          w_state_nxt = S_RD_DATA;
        end else begin
          w_state_nxt = S_RD_WAIT;
        end
      end
      S_RD_DATA: begin
        if (w_cs_n) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_fall) begin
          w_tx_shift  = 1'b1;
          w_state_nxt = S_RD_DATA;
        end else if (w_rise) begin
          w_cnt_inc   = 1'b1;
          w_state_nxt = (r_bit_cnt == CNT_W'(FRAME_W - 1)) ? S_DONE : S_RD_DATA;
        end else begin
          w_state_nxt = S_RD_DATA;
        end
      end
      S_WR_DATA: begin
        if (w_cs_n) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_rise) begin
          w_rx_shift = 1'b1;
          w_cnt_inc  = 1'b1;
          if (r_bit_cnt == CNT_W'(FRAME_W - 1)) begin
            w_wr_latch  = 1'b1;
            w_state_nxt = S_WR_COMMIT;
          end else begin
            w_state_nxt = S_WR_DATA;
          end
        end else begin
          w_state_nxt = S_WR_DATA;
        end
      end
      S_WR_COMMIT: begin
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (w_cs_n) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath and registered outputs; rwb is derived from the next state so it is low only in WR_COMMIT.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_bit_cnt     <= '0;
      r_rx_sr       <= '0;
      r_tx_sr       <= '0;
      r_wait        <= 1'b0;
      r_miso        <= 1'b0;
      r_miso_oe     <= 1'b0;
      r_mem_add     <= '0;
      r_mem_data_in <= '0;
      r_mem_rwb     <= 1'b1;
      r_frame_done  <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      if (w_cnt_clr) begin
        r_bit_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
      if (w_rx_shift) begin
        r_rx_sr <= {r_rx_sr[DATA_W-3:0], w_mosi};
      end
      if (w_hdr_latch) begin
        r_mem_add <= {r_rx_sr[ADDR_W-2:0], w_mosi};
      end
      if (w_wr_latch) begin
        r_mem_data_in <= {r_rx_sr, w_mosi};
      end
      if (w_tx_load) begin
        r_tx_sr <= mem_data_out;
      end else if (w_tx_shift) begin
        r_tx_sr <= {r_tx_sr[DATA_W-2:0], 1'b0};
      end
      r_wait <= (r_state == S_RD_WAIT) && !r_wait;
      if (w_state_nxt != S_RD_DATA) begin
        r_miso <= 1'b0;
      end else if (w_tx_shift) begin
        r_miso <= r_tx_sr[DATA_W-1];
      end
      r_miso_oe    <= ~w_cs_n;
      r_mem_rwb    <= (w_state_nxt != S_WR_COMMIT);
      r_frame_done <= (w_state_nxt == S_DONE) && (r_state != S_DONE);
      r_frame_err  <= w_abort;
    end
  end

  assign miso        = r_miso;
  assign miso_oe     = r_miso_oe;
  assign mem_add     = r_mem_add;
  assign mem_data_in = r_mem_data_in;
  assign mem_rwb     = r_mem_rwb;
  assign frame_done  = r_frame_done;
  assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench for spi_slave_ctrl: an SPI master task drives frames, a registered memory model
// answers reads, and a monitor counts write commits and done/error pulses.
module tb_spi_slave_ctrl;

  logic        clk;
  logic        rstn;
  logic        sclk;
  logic        cs_n;
  logic        mosi;
  logic        miso;
  logic        miso_oe;
  logic [6:0]  mem_add;
  logic [15:0] mem_data_in;
  logic        mem_rwb;
  logic [15:0] mem_data_out;
  logic        frame_done;
  logic        frame_err;

  int n_cmp;
  int n_err;
  int commit_cnt;
  int done_cnt;
  int err_cnt;
  logic [6:0]  last_add;
  logic [15:0] last_data;
  logic [15:0] mem [0:127];

  spi_slave_ctrl #(.SYNC_STAGES(2), .ADDR_W(7), .DATA_W(16)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .sclk         (sclk),
    .cs_n         (cs_n),
    .mosi         (mosi),
    .miso         (miso),
    .miso_oe      (miso_oe),
    .mem_add      (mem_add),
    .mem_data_in  (mem_data_in),
    .mem_rwb      (mem_rwb),
    .mem_data_out (mem_data_out),
    .frame_done   (frame_done),
    .frame_err    (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered memory: writes whenever rwb is low, read data one clk after the address.
  always @(posedge clk) begin
    if (!mem_rwb) mem[mem_add] <= mem_data_in;
    mem_data_out <= mem[mem_add];
  end

  // Monitor sampled away from the active edge.
  always @(negedge clk) begin
    if (rstn && !mem_rwb) begin
      commit_cnt = commit_cnt + 1;
      last_add   = mem_add;
      last_data  = mem_data_in;
    end
    if (rstn && frame_done) done_cnt = done_cnt + 1;
    if (rstn && frame_err)  err_cnt  = err_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One SPI mode-0 frame of nbits clocks; optional async reset after rise rst_at.
  task automatic spi_xfer(input logic [23:0] word, input int nbits, input int rst_at,
                          output logic [23:0] cap, output logic oe_seen);
    cap     = '0;
    oe_seen = 1'b0;
    cs_n    = 1'b0;
    #80;
    for (int i = 0; i < nbits; i++) begin
      if (i < 24) mosi = word[23-i];
      else        mosi = 1'b1;
      #80;
      sclk    = 1'b1;
      cap     = {cap[22:0], miso};
      oe_seen = miso_oe;
      if (i + 1 == rst_at) begin
        #40;
        rstn = 1'b0;
        #1;
        check_val("rst_mid_rwb",   {31'd0, mem_rwb},        32'd1);
        check_val("rst_mid_add",   {25'd0, mem_add},        32'd0);
        check_val("rst_mid_data",  {16'd0, mem_data_in},    32'd0);
        check_val("rst_mid_oe",    {31'd0, miso_oe},        32'd0);
        check_val("rst_mid_miso",  {31'd0, miso},           32'd0);
        check_val("rst_mid_pulse", {30'd0, frame_done, frame_err}, 32'd0);
        sclk = 1'b0;
        break;
      end
      #80;
      sclk = 1'b0;
    end
    #80;
    cs_n = 1'b1;
    mosi = 1'b0;
    #160;
  endtask

  logic [23:0] cap;
  logic        oe;
  int          c0;
  int          d0;
  int          e0;

  initial begin
    n_cmp = 0; n_err = 0;
    commit_cnt = 0; done_cnt = 0; err_cnt = 0;
    last_add = '0; last_data = '0;
    rstn = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    #22;
    check_val("reset_rwb",  {31'd0, mem_rwb},     32'd1);
    check_val("reset_add",  {25'd0, mem_add},     32'd0);
    check_val("reset_data", {16'd0, mem_data_in}, 32'd0);
    check_val("reset_miso", {30'd0, miso_oe, miso}, 32'd0);
    check_val("reset_pulse", {30'd0, frame_done, frame_err}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    check_val("idle_rwb", {31'd0, mem_rwb}, 32'd1);
    check_val("idle_oe",  {31'd0, miso_oe}, 32'd0);

    // Write 0xA5C3 to 0x05.
    c0 = commit_cnt; d0 = done_cnt; e0 = err_cnt;
    spi_xfer({1'b0, 7'h05, 16'hA5C3}, 24, -1, cap, oe);
    check_val("wr1_commits", commit_cnt - c0, 32'd1);
    check_val("wr1_add",     {25'd0, last_add},   32'h05);
    check_val("wr1_data",    {16'd0, last_data},  32'hA5C3);
    check_val("wr1_done",    done_cnt - d0,       32'd1);

    // Read back 0x05.
    c0 = commit_cnt; d0 = done_cnt;
    spi_xfer({1'b1, 7'h05, 16'h0000}, 24, -1, cap, oe);
    check_val("rd1_miso",    {16'd0, cap[15:0]}, 32'hA5C3);
    check_val("rd1_hdr_miso", {24'd0, cap[23:16]}, 32'h00);
    check_val("rd1_commits", commit_cnt - c0, 32'd0);
    check_val("rd1_done",    done_cnt - d0,   32'd1);

    // Back-to-back writes to the address extremes.
    c0 = commit_cnt; d0 = done_cnt;
    spi_xfer({1'b0, 7'h7F, 16'h0001}, 24, -1, cap, oe);
    check_val("b2b1_add",  {25'd0, last_add},  32'h7F);
    check_val("b2b1_data", {16'd0, last_data}, 32'h0001);
    spi_xfer({1'b0, 7'h00, 16'hFFFF}, 24, -1, cap, oe);
    check_val("b2b2_add",  {25'd0, last_add},  32'h00);
    check_val("b2b2_data", {16'd0, last_data}, 32'hFFFF);
    check_val("b2b_commits", commit_cnt - c0, 32'd2);
    check_val("b2b_done",    done_cnt - d0,   32'd2);

    // Abort a write to 0x10 after 20 bits, then read 0x7F.
    c0 = commit_cnt; d0 = done_cnt; e0 = err_cnt;
    spi_xfer({1'b0, 7'h10, 16'h1357}, 20, -1, cap, oe);
    check_val("abort_err",     err_cnt - e0,    32'd1);
    check_val("abort_commits", commit_cnt - c0, 32'd0);
    check_val("abort_done",    done_cnt - d0,   32'd0);
    spi_xfer({1'b1, 7'h7F, 16'h0000}, 24, -1, cap, oe);
    check_val("post_abort_rd", {16'd0, cap[15:0]}, 32'h0001);
    check_val("post_abort_done", done_cnt - d0, 32'd1);

    // Async reset at bit 12 of a write, then a clean write.
    c0 = commit_cnt;
    spi_xfer({1'b0, 7'h10, 16'hBEEF}, 24, 12, cap, oe);
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    check_val("rst_commits", commit_cnt - c0, 32'd0);
    c0 = commit_cnt; d0 = done_cnt;
    spi_xfer({1'b0, 7'h33, 16'h1234}, 24, -1, cap, oe);
    check_val("post_rst_commits", commit_cnt - c0, 32'd1);
    check_val("post_rst_add",  {25'd0, last_add},  32'h33);
    check_val("post_rst_data", {16'd0, last_data}, 32'h1234);
    check_val("post_rst_done", done_cnt - d0, 32'd1);

    // 30 sclk pulses: extra bits must not cause a second commit.
    c0 = commit_cnt; d0 = done_cnt; e0 = err_cnt;
    spi_xfer({1'b0, 7'h22, 16'h5A5A}, 30, -1, cap, oe);
    check_val("extra_commits", commit_cnt - c0, 32'd1);
    check_val("extra_add",  {25'd0, last_add},  32'h22);
    check_val("extra_data", {16'd0, last_data}, 32'h5A5A);
    check_val("extra_done", done_cnt - d0, 32'd1);
    check_val("extra_err",  err_cnt - e0,  32'd0);
    check_val("extra_miso_zero", {8'd0, cap}, 32'd0);
    check_val("extra_oe_during", {31'd0, oe},      32'd1);
    check_val("extra_oe_after",  {31'd0, miso_oe}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
